network_output_queue: RTL

//  Per-port egress queue manager feeding the network transmit stage.
//  - Holds forwarded pkt_bufids in NUM_QUEUE FIFOs, one per queue_id/priority.
//  - Picks one bufid by strict priority; queue NUM_QUEUE-1 is highest.
//  - Hands it downstream over a wr/ack handshake.
//  - One instance per network interface; its outputs drive iv_pkt_bufid/i_pkt_bufid_wr of the tx stage.

---
 rtl/network_output_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/network_output_queue.sv
// rtl/network_output_queue.sv - per-port strict-priority egress queue manager with wr/ack handoff
// Optional feature macro: GATE_CTRL_EN (adds iv_gate_state per-queue gate inputs)
module network_output_queue #(
    parameter int NUM_QUEUE   = 8,
    parameter int QUEUE_DEPTH = 16,
    parameter int BUFID_W     = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BUFID_W-1:0]   iv_pkt_bufid,
    input  logic [2:0]           iv_pkt_queue_id,
    input  logic                 i_pkt_bufid_wr,
    output logic [BUFID_W-1:0]   ov_pkt_bufid,
    output logic                 o_pkt_bufid_wr,
    input  logic                 i_pkt_bufid_ack,
    output logic [BUFID_W-1:0]   ov_drop_bufid,
    output logic                 o_drop_bufid_wr,
    output logic [NUM_QUEUE-1:0] ov_queue_empty,
    output logic [1:0]           ov_oqm_state
`ifdef GATE_CTRL_EN
    ,
    input  logic [NUM_QUEUE-1:0] iv_gate_state
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int QID_W = 3;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        SEL_S      = 2'd1,
        WAIT_ACK_S = 2'd2
    } state_t;

    logic [BUFID_W-1:0]   mem_q [NUM_QUEUE][QUEUE_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_QUEUE];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_QUEUE];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_QUEUE];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_QUEUE];
    logic [CNT_W-1:0]     count_q  [NUM_QUEUE];
    logic [CNT_W-1:0]     count_d  [NUM_QUEUE];
    logic [NUM_QUEUE-1:0] empty_q, empty_d;

    state_t               state_q, state_d;
    logic [QID_W-1:0]     sel_q, sel_d;
    logic [BUFID_W-1:0]   bufid_q, bufid_d;
    logic                 wr_q, wr_d;
    logic [BUFID_W-1:0]   drop_bufid_q, drop_bufid_d;
    logic                 drop_wr_q, drop_wr_d;

    logic                 full_in, push_ok, pop_en;
    logic [NUM_QUEUE-1:0] push_vec, pop_vec, elig;
    logic [QID_W-1:0]     hi_q_idx;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues an enqueue.
    always_comb begin
        full_in  = (count_q[iv_pkt_queue_id] == CNT_W'(QUEUE_DEPTH));
        push_ok  = i_pkt_bufid_wr && !full_in;
        pop_en   = (state_q == WAIT_ACK_S) && i_pkt_bufid_ack;
        push_vec = push_ok ? (NUM_QUEUE'(1) << iv_pkt_queue_id) : '0;
        pop_vec  = pop_en  ? (NUM_QUEUE'(1) << sel_q) : '0;
    end

    always_comb begin
`ifdef GATE_CTRL_EN
        elig = ~empty_q & iv_gate_state;
`else
        elig = ~empty_q;
`endif
        hi_q_idx = '0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            if (elig[q]) begin
                hi_q_idx = QID_W'(q);
            end
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_QUEUE; q++) begin
            rd_ptr_d[q] = rd_ptr_q[q];
            wr_ptr_d[q] = wr_ptr_q[q];
            count_d[q]  = count_q[q];
            if (push_vec[q]) begin
                wr_ptr_d[q] = wr_ptr_q[q] + PTR_W'(1);
            end
            if (pop_vec[q]) begin
                rd_ptr_d[q] = rd_ptr_q[q] + PTR_W'(1);
            end
            count_d[q] = count_q[q] + {{(CNT_W-1){1'b0}}, push_vec[q]}
                                    - {{(CNT_W-1){1'b0}}, pop_vec[q]};
            empty_d[q] = (count_d[q] == '0);
        end
    end

    always_comb begin
        drop_wr_d    = i_pkt_bufid_wr && full_in;
        drop_bufid_d = drop_wr_d ? iv_pkt_bufid : drop_bufid_q;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        bufid_d = bufid_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE_S: begin
                if (|elig) begin
                    state_d = SEL_S;
                end
            end
            SEL_S: begin
                if (|elig) begin
                    sel_d   = hi_q_idx;
                    bufid_d = mem_q[hi_q_idx][rd_ptr_q[hi_q_idx]];
                    wr_d    = 1'b1;
                    state_d = WAIT_ACK_S;
                end else begin
                    state_d = IDLE_S;
                end
            end
            WAIT_ACK_S: begin
                if (i_pkt_bufid_ack) begin
                    wr_d    = 1'b0;
                    state_d = IDLE_S;
                end
            end
            default: begin
                wr_d    = 1'b0;
                state_d = IDLE_S;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int q = 0; q < NUM_QUEUE; q++) begin
                rd_ptr_q[q] <= '0;
                wr_ptr_q[q] <= '0;
                count_q[q]  <= '0;
            end
            empty_q      <= '1;
            state_q      <= IDLE_S;
            sel_q        <= '0;
            bufid_q      <= '0;
            wr_q         <= 1'b0;
            drop_bufid_q <= '0;
            drop_wr_q    <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_QUEUE; q++) begin
                rd_ptr_q[q] <= rd_ptr_d[q];
                wr_ptr_q[q] <= wr_ptr_d[q];
                count_q[q]  <= count_d[q];
            end
            empty_q      <= empty_d;
            state_q      <= state_d;
            sel_q        <= sel_d;
            bufid_q      <= bufid_d;
            wr_q         <= wr_d;
            drop_bufid_q <= drop_bufid_d;
            drop_wr_q    <= drop_wr_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[iv_pkt_queue_id][wr_ptr_q[iv_pkt_queue_id]] <= iv_pkt_bufid;
        end
    end

    assign ov_pkt_bufid    = bufid_q;
    assign o_pkt_bufid_wr  = wr_q;
    assign ov_drop_bufid   = drop_bufid_q;
    assign o_drop_bufid_wr = drop_wr_q;
    assign ov_queue_empty  = empty_q;
    assign ov_oqm_state    = state_q;

endmodule
